// File: rtl/aon_rtc_counter_if.sv
// Load handshake bundle for the AON real-time counter.
// The master drives the load request; the slave answers with load_ready.
interface aon_rtc_counter_if #(
  parameter int unsigned CNT_WIDTH = 48
);
  logic                 load_valid;
  logic [CNT_WIDTH-1:0] load_data;
  logic                 load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/aon_rtc_counter.sv
// Always-on real-time counter: counts rising edges of the divided lfclk level,
// exposes a scaled view with a sticky compare-match interrupt and a load port.
module aon_rtc_counter #(
  parameter int unsigned CNT_WIDTH   = 48,
  parameter int unsigned CMP_WIDTH   = 32,
  parameter int unsigned SCALE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   lfclk_in,
  input  logic                   enable,
  input  logic [SCALE_WIDTH-1:0] scale,
  input  logic [CMP_WIDTH-1:0]   cmp_value,
  input  logic                   ip_clear,
  aon_rtc_counter_if.slave       load_if,
  output logic [CNT_WIDTH-1:0]   count_out,
  output logic [CMP_WIDTH-1:0]   scaled_out,
  output logic                   tick_out,
  output logic                   ip
);

  localparam int unsigned SHW = (CNT_WIDTH > CMP_WIDTH) ? CNT_WIDTH : CMP_WIDTH;

  logic                 s1;
  logic                 s2;
  logic                 prev;
  logic                 lf_edge;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 tick_q;
  logic                 ip_q;
  logic                 ready_q;
  logic                 load_accept;
  logic [SHW-1:0]       count_ext;
  logic                 match;

  assign lf_edge     = s2 & ~prev;
  assign load_accept = load_if.load_valid & ready_q;

  // Zero-extend before shifting so bits above the counter read as 0.
  assign count_ext   = SHW'(count_q);
  assign scaled_out  = CMP_WIDTH'(count_ext >> scale);
  assign match       = (scaled_out >= cmp_value);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      prev    <= 1'b0;
      count_q <= '0;
      tick_q  <= 1'b0;
      ip_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      // Edge history keeps tracking while disabled so re-enable never counts a stale level.
      s1      <= lfclk_in;
      s2      <= s1;
      prev    <= s2;
      ready_q <= ~load_accept;

      if (load_accept) begin
        count_q <= load_if.load_data;
        tick_q  <= 1'b0;
      end else if (enable && lf_edge) begin
        count_q <= count_q + CNT_WIDTH'(1);
        tick_q  <= 1'b1;
      end else begin
        tick_q  <= 1'b0;
      end

      if (match) begin
        ip_q <= 1'b1;
      end else if (ip_clear) begin
        ip_q <= 1'b0;
      end
    end
  end

  assign load_if.load_ready = ready_q;
  assign count_out          = count_q;
  assign tick_out           = tick_q;
  assign ip                 = ip_q;

endmodule

// File: tb/tb_aon_rtc_counter.sv
// Directed testbench for aon_rtc_counter with hand-computed expectations.
module tb_aon_rtc_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lfclk_in;
  logic        enable;
  logic [3:0]  scale;
  logic [31:0] cmp_value;
  logic        ip_clear;
  logic [47:0] count_out;
  logic [31:0] scaled_out;
  logic        tick_out;
  logic        ip;

  logic [47:0] model_cnt;
  int          tick_cnt = 0;
  int          n_vec    = 0;
  int          n_miss   = 0;

  aon_rtc_counter_if #(.CNT_WIDTH(48)) load_bus ();

  aon_rtc_counter #(
    .CNT_WIDTH   (48),
    .CMP_WIDTH   (32),
    .SCALE_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lfclk_in   (lfclk_in),
    .enable     (enable),
    .scale      (scale),
    .cmp_value  (cmp_value),
    .ip_clear   (ip_clear),
    .load_if    (load_bus.slave),
    .count_out  (count_out),
    .scaled_out (scaled_out),
    .tick_out   (tick_out),
    .ip         (ip)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && tick_out) tick_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Raise lfclk and walk through the three synchroniser edges.
  task automatic lf_rise(input bit inc);
    lfclk_in = 1'b1;
    steps(2);
    check("cnt_pre_e3", count_out, model_cnt);
    if (inc) model_cnt = model_cnt + 48'd1;
    step();
    check("cnt_e3", count_out, model_cnt);
    check("tick_e3", tick_out, inc);
  endtask

  task automatic lf_hold(input int hi_rest, input int lo);
    steps(hi_rest);
    lfclk_in = 1'b0;
    steps(lo);
  endtask

  initial begin
    reset_n             = 1'b0;
    lfclk_in            = 1'b0;
    enable              = 1'b0;
    scale               = 4'd0;
    cmp_value           = 32'hFFFF_FFFF;
    ip_clear            = 1'b0;
    load_bus.load_valid = 1'b0;
    load_bus.load_data  = '0;
    model_cnt           = '0;

    steps(3);
    check("rst_count", count_out, 48'd0);
    check("rst_tick", tick_out, 1'b0);
    check("rst_ip", ip, 1'b0);
    check("rst_ready", load_bus.load_ready, 1'b1);
    reset_n = 1'b1;
    enable  = 1'b1;
    step();

    // Basic count, 512-cycle lfclk period.
    for (int p = 0; p < 5; p++) begin
      lf_rise(1'b1);
      lf_hold(253, 256);
    end
    check("basic_count", count_out, 48'd5);
    check("basic_ticks", tick_cnt, 5);

    // Enable gating, then re-enable while lfclk is high.
    enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      lf_rise(1'b0);
      lf_hold(5, 8);
    end
    lfclk_in = 1'b1;
    steps(4);
    enable = 1'b1;
    steps(4);
    check("gate_count", count_out, 48'd5);
    check("gate_ticks", tick_cnt, 5);
    lfclk_in = 1'b0;
    steps(4);
    lf_rise(1'b1);
    lf_hold(4, 4);
    check("reen_count", count_out, 48'd6);

    // Load collides with an edge; second load held across the not-ready cycle.
    lfclk_in = 1'b1;
    steps(2);
    load_bus.load_valid = 1'b1;
    load_bus.load_data  = 48'h0000_FFFF_FFFF;
    step();
    model_cnt = 48'h0000_FFFF_FFFF;
    check("coll_count", count_out, model_cnt);
    check("coll_tick", tick_out, 1'b0);
    check("coll_ready", load_bus.load_ready, 1'b0);
    load_bus.load_data = 48'h0000_0000_0010;
    step();
    check("held_count", count_out, 48'h0000_FFFF_FFFF);
    check("held_ready", load_bus.load_ready, 1'b1);
    step();
    model_cnt = 48'h10;
    check("second_count", count_out, model_cnt);
    check("second_ready", load_bus.load_ready, 1'b0);
    load_bus.load_valid = 1'b0;
    step();
    check("ready_back", load_bus.load_ready, 1'b1);
    check("coll_ticks", tick_cnt, 6);
    lfclk_in = 1'b0;
    steps(4);
    ip_clear = 1'b1;
    step();
    ip_clear = 1'b0;
    check("pre_wrap_ip", ip, 1'b0);

    // Wrap with ip set: wrap must not clear it.
    load_bus.load_valid = 1'b1;
    load_bus.load_data  = 48'hFFFF_FFFF_FFFF;
    step();
    load_bus.load_valid = 1'b0;
    model_cnt = 48'hFFFF_FFFF_FFFF;
    check("wrap_load", count_out, model_cnt);
    check("wrap_ip0", ip, 1'b0);
    step();
    check("wrap_ip1", ip, 1'b1);
    lf_rise(1'b1);
    check("wrap_zero", count_out, 48'd0);
    check("wrap_ip_e3", ip, 1'b1);
    step();
    check("wrap_ip_hold", ip, 1'b1);
    lf_hold(0, 4);
    ip_clear = 1'b1;
    step();
    ip_clear = 1'b0;
    check("wrap_ip_clr", ip, 1'b0);

    // Scale 4, compare 3: match at count 48.
    scale     = 4'd4;
    cmp_value = 32'd3;
    step();
    for (int k = 1; k <= 48; k++) begin
      lf_rise(1'b1);
      check("scaled", scaled_out, k / 16);
      check("ip_before", ip, 1'b0);
      if (k == 48) begin
        step();
        check("ip_match", ip, 1'b1);
        lf_hold(0, 4);
      end else begin
        lf_hold(1, 4);
      end
    end
    ip_clear = 1'b1;
    step();
    ip_clear = 1'b0;
    check("clr_while_match", ip, 1'b1);
    load_bus.load_valid = 1'b1;
    load_bus.load_data  = 48'd0;
    step();
    load_bus.load_valid = 1'b0;
    model_cnt = 48'd0;
    check("reload0", count_out, 48'd0);
    check("reload0_ip", ip, 1'b1);
    ip_clear = 1'b1;
    step();
    ip_clear = 1'b0;
    check("clr_after_load", ip, 1'b0);

    // Asynchronous reset mid-count with a load in flight.
    scale     = 4'd0;
    cmp_value = 32'd5;
    load_bus.load_valid = 1'b1;
    load_bus.load_data  = 48'd37;
    step();
    load_bus.load_valid = 1'b0;
    step();
    check("pre_rst_count", count_out, 48'd37);
    check("pre_rst_ip", ip, 1'b1);
    load_bus.load_valid = 1'b1;
    load_bus.load_data  = 48'd99;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", count_out, 48'd0);
    check("arst_ip", ip, 1'b0);
    check("arst_tick", tick_out, 1'b0);
    check("arst_ready", load_bus.load_ready, 1'b1);
    step();
    check("arst_hold_count", count_out, 48'd0);
    load_bus.load_valid = 1'b0;
    reset_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
